ex_stage: RTL and testbench
===========================

// Module: ex_stage
// PURPOSE
//  Execute stage fed by the ID/EX pipeline register. Resolves forwarding, runs the ALU/shifter,
//  computes memory addresses, resolves branches/jumps/traps and latches results into the EX/MEM
//  register (valid bit, stall, squash). Also issues a one-cycle redirect to fetch and squashes
//  wrong-path ops that are already in flight.
// PARAMETERS
//  SQUASH_DEPTH  2   ops after a taken redirect that this stage drops (wrong-path depth in IF/ID)
// PORTS
//  clk              in   1    clock; all state on posedge
//  reset_n          in   1    asynchronous, active-low reset
//  valid_in         in   1    ID/EX slot holds a real op
//  ctrl_in          in   ctrl lc3b_control_word (opcode, aluop, alub_sel, mem_read, mem_write, load_regfile)
//  sr1_in, sr2_in   in   16   register operands read in ID
//  offset6_in       in   16   sext(offset6/imm5) operand
//  branch_offset_in in   16   sext(PCoffset9/11)<<1
//  nzp_in           in   3    BR condition bits
//  dest_in          in   3    destination register
//  pc_in            in   16   PC+2 of the op
//  dest_data_in     in   16   store data (STR source register)
//  trapvector_in    in   16   zext(trapvect8)<<1
//  shfval_in        in   4    shift amount
//  cc_in            in   3    architectural condition codes (n,z,p)
//  fwd_a_sel, fwd_b_sel in 2  00 reg, 01 EX/MEM result, 10 MEM/WB data, 11 reserved (=reg)
//  fwd_mem_data, fwd_wb_data in 16 forwarded values
//  stall_pipeline   in   1    hold the EX/MEM register and the squash counter
//  valid_out        out  1    EX/MEM slot valid
//  ctrl_out         out  ctrl registered control word (cleared to 0 when invalid)
//  result_out       out  16   ALU result, or link PC for JSR/JSRR/TRAP
//  addr_out         out  16   memory address (base+offset6)
//  store_data_out   out  16   forwarded store data
//  dest_out         out  3    destination register
//  pc_out           out  16   pass-through PC+2
//  redirect_out     out  1    one-cycle pulse: fetch must load redirect_pc_out
//  redirect_pc_out  out  16   branch/jump/trap target
// BEHAVIOUR
//  - Reset (async, reset_n=0): every output and internal register = 0; squash_cnt = 0.
//  - Latency: 1 cycle. The EX/MEM register updates on the posedge when stall_pipeline=0.
//    When stall_pipeline=1, all outputs hold, including redirect_out.
//  - Operand A = fwd(sr1_in, fwd_a_sel). Operand B = alub_sel ? offset6_in : fwd(sr2_in, fwd_b_sel).
//    Store data = fwd(dest_data_in, fwd_b_sel).
//  - ALU (16-bit, carry discarded): ADD, AND, NOT (A), PASS (B), SLL, SRL, SRA (sign fill); shift count = shfval_in.
//  - addr = A + offset6_in, mod 2^16.
//  - Control transfer:
//    - BR taken iff |(nzp_in & cc_in); target pc_in + branch_offset_in.
//    - JMP/JSRR: target = A.
//    - JSR: target = pc_in + branch_offset_in.
//    - TRAP: target = trapvector_in.
//    - JSR/JSRR/TRAP write result = pc_in.
//  - eff_valid = valid_in & (squash_cnt == 0).
//  - Taken transfer with eff_valid (not stalled): register redirect_out=1 and redirect_pc_out,
//    and set squash_cnt = SQUASH_DEPTH. The transfer op itself stays valid in EX/MEM.
//  - Each non-stalled cycle with squash_cnt>0: decrement squash_cnt, and force valid_out=0 and
//    ctrl_out=0 (bubble) whatever valid_in is. Empty slots (valid_in=0) still decrement.
//  - redirect_out deasserts on the next non-stalled edge. It never stays high for two advancing cycles.
//  - Ops without eff_valid cannot redirect; this covers a branch arriving during a squash.
//  - Stall together with a taken branch: nothing changes until the stall clears; then the redirect fires once.
//  - Reset mid-squash: the counter clears immediately and the next op is accepted.
// STRUCTURE
//  - lc3b_types gains lc3b_aluop members (alu_pass, alu_srl, alu_sra) if not present, plus a
//    lc3b_fwd_sel enum and the EX/MEM field widths.
//  - One sub-module: ex_alu (combinational ALU + shifter). Forwarding muxes, branch resolution,
//    the squash counter and the EX/MEM register live in ex_stage.
// TESTING
//  1. ADD: A=0x0005, B=0x0003 (regs), fwd 00 -> next cycle result_out=0x0008, valid_out=1, redirect_out=0.
//  2. SRA: A=0x8004, shfval=2 -> result_out=0xE001. SRL on the same input -> 0x2001.
//  3. Forwarding: sr1_in=0x1111, fwd_a_sel=01, fwd_mem_data=0x00F0, ADD imm 1 -> result_out=0x00F1.
//  4. BRz, cc_in=010, pc_in=0x3002, offset=0x0010 -> redirect_out pulse, redirect_pc_out=0x3012;
//     the next 2 valid ops produce valid_out=0; the 3rd is accepted. With cc_in=100: no redirect, no squash.
//  5. TRAP x25 with stall_pipeline held high 3 cycles -> no output change; then one redirect to 0x004A
//     and result_out=pc_in.
//  6. Assert reset_n=0 mid-squash, asynchronously between edges -> all outputs 0 at once;
//     after release, the next ADD is valid.

Source files
------------

// File: rtl/ex_stage_pkg.sv
// ----------------------------------------------------------------------------
// ex_stage_pkg
//   Shared LC-3b types for the execute stage: opcode and ALU-operation enums,
//   the forwarding-select enum, the control word carried down the pipe, the
//   EX/MEM field widths and the forwarding mux helper.
//   No ports (package).
// ----------------------------------------------------------------------------
package ex_stage_pkg;

   localparam int WORD_W = 16;
   localparam int DEST_W = 3;
   localparam int NZP_W  = 3;
   localparam int SHF_W  = 4;
   localparam int FWD_W  = 2;

   typedef enum logic [3:0] {
      op_br   = 4'b0000,
      op_add  = 4'b0001,
      op_ldb  = 4'b0010,
      op_stb  = 4'b0011,
      op_jsr  = 4'b0100,
      op_and  = 4'b0101,
      op_ldr  = 4'b0110,
      op_str  = 4'b0111,
      op_rti  = 4'b1000,
      op_not  = 4'b1001,
      op_ldi  = 4'b1010,
      op_sti  = 4'b1011,
      op_jmp  = 4'b1100,
      op_shf  = 4'b1101,
      op_lea  = 4'b1110,
      op_trap = 4'b1111
   } lc3b_opcode;

   typedef enum logic [2:0] {
      alu_add  = 3'd0,
      alu_and  = 3'd1,
      alu_not  = 3'd2,
      alu_pass = 3'd3,
      alu_sll  = 3'd4,
      alu_srl  = 3'd5,
      alu_sra  = 3'd6
   } lc3b_aluop;

   typedef enum logic [FWD_W-1:0] {
      fwd_reg   = 2'b00,
      fwd_exmem = 2'b01,
      fwd_memwb = 2'b10,
      fwd_rsvd  = 2'b11
   } lc3b_fwd_sel;

   // jsr_imm is instruction bit 11: set for JSR (PC-relative target),
   // clear for JSRR (register target). Both share the JSR opcode.
   typedef struct packed {
      lc3b_opcode opcode;
      lc3b_aluop  aluop;
      logic       alub_sel;
      logic       mem_read;
      logic       mem_write;
      logic       load_regfile;
      logic       jsr_imm;
   } lc3b_control_word;

   // The reserved select code falls back to the register-file value.
   function automatic logic [WORD_W-1:0] fwdMux(
      input logic [WORD_W-1:0] regVal,
      input lc3b_fwd_sel       sel,
      input logic [WORD_W-1:0] memVal,
      input logic [WORD_W-1:0] wbVal
   );
      case (sel)
         fwd_exmem: fwdMux = memVal;
         fwd_memwb: fwdMux = wbVal;
         default:   fwdMux = regVal;
      endcase
   endfunction

endpackage

// File: rtl/ex_alu.sv
// ----------------------------------------------------------------------------
// ex_alu
//   Combinational 16-bit ALU and barrel shifter. Carry out is discarded.
//   Ports:
//     i_aluop   in   operation select (lc3b_aluop)
//     i_a       in   16  operand A (also the shifted operand)
//     i_b       in   16  operand B
//     i_shf     in   4   shift amount
//     o_result  out  16  result
// ----------------------------------------------------------------------------
module ex_alu
   import ex_stage_pkg::*;
(
   input  lc3b_aluop         i_aluop,
   input  logic [WORD_W-1:0] i_a,
   input  logic [WORD_W-1:0] i_b,
   input  logic [SHF_W-1:0]  i_shf,
   output logic [WORD_W-1:0] o_result
);

   // One operation per opcode; shifts always act on operand A, and the
   // arithmetic right shift refills with A's sign bit.
   always_comb begin
      o_result = '0;
      case (i_aluop)
         alu_add:  o_result = i_a + i_b;
         alu_and:  o_result = i_a & i_b;
         alu_not:  o_result = ~i_a;
         alu_pass: o_result = i_b;
         alu_sll:  o_result = i_a << i_shf;
         alu_srl:  o_result = i_a >> i_shf;
         alu_sra:  o_result = $unsigned($signed(i_a) >>> i_shf);
         default:  o_result = '0;
      endcase
   end

endmodule

// File: rtl/ex_stage.sv
// ----------------------------------------------------------------------------
// ex_stage
//   LC-3b execute stage. Selects forwarded operands, runs the ALU, forms the
//   memory address, resolves BR/JMP/JSR/JSRR/TRAP, and latches everything
//   into the EX/MEM register. A taken transfer pulses redirect_out for one
//   advancing cycle and drops the next SQUASH_DEPTH slots as bubbles.
//   Ports:
//     clk, reset_n                 clock, async active-low reset
//     valid_in, ctrl_in            ID/EX slot valid and control word
//     sr1_in, sr2_in               register operands
//     offset6_in                   sign-extended offset6/imm5
//     branch_offset_in             sign-extended PC offset, already <<1
//     nzp_in, cc_in                BR condition bits / architectural CCs
//     dest_in, pc_in               destination register, PC+2 of the op
//     dest_data_in                 store source register value
//     trapvector_in                zext(trapvect8)<<1
//     shfval_in                    shift amount
//     fwd_a_sel, fwd_b_sel         forwarding selects
//     fwd_mem_data, fwd_wb_data    forwarded values
//     stall_pipeline               hold EX/MEM and the squash counter
//     valid_out ... pc_out         EX/MEM register outputs
//     redirect_out, redirect_pc_out  one-cycle fetch redirect and target
// ----------------------------------------------------------------------------
module ex_stage
   import ex_stage_pkg::*;
#(
   parameter int SQUASH_DEPTH = 2
)
(
   input  logic                    clk,
   input  logic                    reset_n,
   input  logic                    valid_in,
   input  lc3b_control_word        ctrl_in,
   input  logic [WORD_W-1:0]       sr1_in,
   input  logic [WORD_W-1:0]       sr2_in,
   input  logic [WORD_W-1:0]       offset6_in,
   input  logic [WORD_W-1:0]       branch_offset_in,
   input  logic [NZP_W-1:0]        nzp_in,
   input  logic [DEST_W-1:0]       dest_in,
   input  logic [WORD_W-1:0]       pc_in,
   input  logic [WORD_W-1:0]       dest_data_in,
   input  logic [WORD_W-1:0]       trapvector_in,
   input  logic [SHF_W-1:0]        shfval_in,
   input  logic [NZP_W-1:0]        cc_in,
   input  logic [FWD_W-1:0]        fwd_a_sel,
   input  logic [FWD_W-1:0]        fwd_b_sel,
   input  logic [WORD_W-1:0]       fwd_mem_data,
   input  logic [WORD_W-1:0]       fwd_wb_data,
   input  logic                    stall_pipeline,
   output logic                    valid_out,
   output lc3b_control_word        ctrl_out,
   output logic [WORD_W-1:0]       result_out,
   output logic [WORD_W-1:0]       addr_out,
   output logic [WORD_W-1:0]       store_data_out,
   output logic [DEST_W-1:0]       dest_out,
   output logic [WORD_W-1:0]       pc_out,
   output logic                    redirect_out,
   output logic [WORD_W-1:0]       redirect_pc_out
);

   localparam int CNT_W = (SQUASH_DEPTH < 2) ? 1 : $clog2(SQUASH_DEPTH + 1);

   logic [WORD_W-1:0] w_opA;
   logic [WORD_W-1:0] w_opB;
   logic [WORD_W-1:0] w_storeData;
   logic [WORD_W-1:0] w_aluResult;
   logic [WORD_W-1:0] w_result;
   logic [WORD_W-1:0] w_addr;
   logic [WORD_W-1:0] w_pcRel;
   logic [WORD_W-1:0] w_target;
   logic              w_xferTaken;
   logic              w_squashing;
   logic              w_effValid;
   logic              w_taken;

   logic                    r_valid;
   lc3b_control_word        r_ctrl;
   logic [WORD_W-1:0]       r_result;
   logic [WORD_W-1:0]       r_addr;
   logic [WORD_W-1:0]       r_storeData;
   logic [DEST_W-1:0]       r_dest;
   logic [WORD_W-1:0]       r_pc;
   logic                    r_redirect;
   logic [WORD_W-1:0]       r_redirectPc;
   logic [CNT_W-1:0]        r_squashCnt;

   // Operand selection: B switches to the immediate when alub_sel is set,
   // while store data always follows the B-side forwarding select.
   always_comb begin
      w_opA       = fwdMux(sr1_in, lc3b_fwd_sel'(fwd_a_sel), fwd_mem_data, fwd_wb_data);
      w_opB       = ctrl_in.alub_sel ? offset6_in
                  : fwdMux(sr2_in, lc3b_fwd_sel'(fwd_b_sel), fwd_mem_data, fwd_wb_data);
      w_storeData = fwdMux(dest_data_in, lc3b_fwd_sel'(fwd_b_sel), fwd_mem_data, fwd_wb_data);
      w_addr      = w_opA + offset6_in;
   end

   ex_alu u_alu (
      .i_aluop  (ctrl_in.aluop),
      .i_a      (w_opA),
      .i_b      (w_opB),
      .i_shf    (shfval_in),
      .o_result (w_aluResult)
   );

   // Control-transfer resolution. Linking ops (JSR/JSRR/TRAP) replace the
   // ALU result with the return address so writeback needs no extra path.
   always_comb begin
      w_pcRel     = pc_in + branch_offset_in;
      w_xferTaken = 1'b0;
      w_target    = w_pcRel;
      w_result    = w_aluResult;
      case (ctrl_in.opcode)
         op_br: begin
            w_xferTaken = |(nzp_in & cc_in);
            w_target    = w_pcRel;
         end
         op_jmp: begin
            w_xferTaken = 1'b1;
            w_target    = w_opA;
         end
         op_jsr: begin
            w_xferTaken = 1'b1;
            w_target    = ctrl_in.jsr_imm ? w_pcRel : w_opA;
            w_result    = pc_in;
         end
         op_trap: begin
            w_xferTaken = 1'b1;
            w_target    = trapvector_in;
            w_result    = pc_in;
         end
         default: begin
            w_xferTaken = 1'b0;
         end
      endcase
   end

   // A slot that arrives while wrong-path ops are still being dropped can
   // neither write EX/MEM nor redirect fetch.
   always_comb begin
      w_squashing = (r_squashCnt != '0);
      w_effValid  = valid_in & ~w_squashing;
      w_taken     = w_effValid & w_xferTaken;
   end

   // EX/MEM register and squash counter. Everything, including the redirect
   // pulse, freezes under stall so a stalled taken branch fires exactly once
   // after the stall clears. During a squash every slot, empty or not, is
   // turned into a bubble and counts down the remaining wrong-path depth.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_valid      <= 1'b0;
         r_ctrl       <= '0;
         r_result     <= '0;
         r_addr       <= '0;
         r_storeData  <= '0;
         r_dest       <= '0;
         r_pc         <= '0;
         r_redirect   <= 1'b0;
         r_redirectPc <= '0;
         r_squashCnt  <= '0;
      end else if (!stall_pipeline) begin
         r_result    <= w_result;
         r_addr      <= w_addr;
         r_storeData <= w_storeData;
         r_dest      <= dest_in;
         r_pc        <= pc_in;
         if (w_squashing) begin
            r_squashCnt <= r_squashCnt - CNT_W'(1);
            r_valid     <= 1'b0;
            r_ctrl      <= '0;
            r_redirect  <= 1'b0;
         end else begin
            r_valid    <= w_effValid;
            r_ctrl     <= w_effValid ? ctrl_in : '0;
            r_redirect <= w_taken;
            if (w_taken) begin
               r_redirectPc <= w_target;
               r_squashCnt  <= CNT_W'(SQUASH_DEPTH);
            end
         end
      end
   end

   assign valid_out       = r_valid;
   assign ctrl_out        = r_ctrl;
   assign result_out      = r_result;
   assign addr_out        = r_addr;
   assign store_data_out  = r_storeData;
   assign dest_out        = r_dest;
   assign pc_out          = r_pc;
   assign redirect_out    = r_redirect;
   assign redirect_pc_out = r_redirectPc;

endmodule

// File: tb/tb_ex_stage.sv
// ----------------------------------------------------------------------------
// tb_ex_stage
//   Self-checking bench for ex_stage: a table of ALU/forwarding vectors plus
//   hand-written sequences for branch squash, stall and mid-squash reset.
// ----------------------------------------------------------------------------
module tb_ex_stage;
   import ex_stage_pkg::*;

   logic             clk;
   logic             reset_n;
   logic             valid_in;
   lc3b_control_word ctrl_in;
   logic [15:0]      sr1_in, sr2_in, offset6_in, branch_offset_in;
   logic [2:0]       nzp_in, dest_in, cc_in;
   logic [15:0]      pc_in, dest_data_in, trapvector_in;
   logic [3:0]       shfval_in;
   logic [1:0]       fwd_a_sel, fwd_b_sel;
   logic [15:0]      fwd_mem_data, fwd_wb_data;
   logic             stall_pipeline;
   logic             valid_out;
   lc3b_control_word ctrl_out;
   logic [15:0]      result_out, addr_out, store_data_out, pc_out, redirect_pc_out;
   logic [2:0]       dest_out;
   logic             redirect_out;

   int compared   = 0;
   int mismatched = 0;

   ex_stage #(.SQUASH_DEPTH(2)) dut (
      .clk              (clk),
      .reset_n          (reset_n),
      .valid_in         (valid_in),
      .ctrl_in          (ctrl_in),
      .sr1_in           (sr1_in),
      .sr2_in           (sr2_in),
      .offset6_in       (offset6_in),
      .branch_offset_in (branch_offset_in),
      .nzp_in           (nzp_in),
      .dest_in          (dest_in),
      .pc_in            (pc_in),
      .dest_data_in     (dest_data_in),
      .trapvector_in    (trapvector_in),
      .shfval_in        (shfval_in),
      .cc_in            (cc_in),
      .fwd_a_sel        (fwd_a_sel),
      .fwd_b_sel        (fwd_b_sel),
      .fwd_mem_data     (fwd_mem_data),
      .fwd_wb_data      (fwd_wb_data),
      .stall_pipeline   (stall_pipeline),
      .valid_out        (valid_out),
      .ctrl_out         (ctrl_out),
      .result_out       (result_out),
      .addr_out         (addr_out),
      .store_data_out   (store_data_out),
      .dest_out         (dest_out),
      .pc_out           (pc_out),
      .redirect_out     (redirect_out),
      .redirect_pc_out  (redirect_pc_out)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      lc3b_control_word ctrl;
      logic [15:0]      sr1, sr2, off6, destData;
      logic [3:0]       shf;
      logic [1:0]       fa, fb;
      logic [15:0]      memD, wbD;
      logic [15:0]      expResult, expAddr, expStore;
   } vec_t;

   localparam int NVEC = 12;
   vec_t vecs [NVEC];

   function automatic lc3b_control_word mkCtrl(input lc3b_opcode op, input lc3b_aluop a,
                                               input logic bsel, input logic mr,
                                               input logic mw, input logic ld, input logic ji);
      lc3b_control_word c;
      c.opcode       = op;
      c.aluop        = a;
      c.alub_sel     = bsel;
      c.mem_read     = mr;
      c.mem_write    = mw;
      c.load_regfile = ld;
      c.jsr_imm      = ji;
      return c;
   endfunction

   function automatic vec_t mkVec(input lc3b_control_word c,
                                  input logic [15:0] sr1, input logic [15:0] sr2,
                                  input logic [15:0] off6, input logic [15:0] destData,
                                  input logic [3:0] shf, input logic [1:0] fa, input logic [1:0] fb,
                                  input logic [15:0] memD, input logic [15:0] wbD,
                                  input logic [15:0] er, input logic [15:0] ea, input logic [15:0] es);
      vec_t v;
      v.ctrl = c; v.sr1 = sr1; v.sr2 = sr2; v.off6 = off6; v.destData = destData;
      v.shf = shf; v.fa = fa; v.fb = fb; v.memD = memD; v.wbD = wbD;
      v.expResult = er; v.expAddr = ea; v.expStore = es;
      return v;
   endfunction

   task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
      compared++;
      if (act !== exp) begin
         mismatched++;
         $display("[TB] FAIL %s: got %h, expected %h", name, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Drives one valid op; control-transfer fields are set separately.
   task automatic applyStimulus(input lc3b_control_word c, input logic [15:0] sr1,
                                input logic [15:0] sr2, input logic [15:0] off6,
                                input logic [15:0] destData, input logic [3:0] shf,
                                input logic [1:0] fa, input logic [1:0] fb,
                                input logic [15:0] memD, input logic [15:0] wbD,
                                input logic [15:0] pc, input logic [2:0] dest);
      valid_in     = 1'b1;
      ctrl_in      = c;
      sr1_in       = sr1;
      sr2_in       = sr2;
      offset6_in   = off6;
      dest_data_in = destData;
      shfval_in    = shf;
      fwd_a_sel    = fa;
      fwd_b_sel    = fb;
      fwd_mem_data = memD;
      fwd_wb_data  = wbD;
      pc_in        = pc;
      dest_in      = dest;
   endtask

   task automatic setXfer(input logic [15:0] boff, input logic [2:0] nzp,
                          input logic [2:0] cc, input logic [15:0] tv);
      branch_offset_in = boff;
      nzp_in           = nzp;
      cc_in            = cc;
      trapvector_in    = tv;
   endtask

   task automatic checkAllZero(input string tag);
      checkOutput({tag, ".valid"},    32'(valid_out),       32'h0);
      checkOutput({tag, ".ctrl"},     32'(ctrl_out),        32'h0);
      checkOutput({tag, ".result"},   32'(result_out),      32'h0);
      checkOutput({tag, ".addr"},     32'(addr_out),        32'h0);
      checkOutput({tag, ".store"},    32'(store_data_out),  32'h0);
      checkOutput({tag, ".dest"},     32'(dest_out),        32'h0);
      checkOutput({tag, ".pc"},       32'(pc_out),          32'h0);
      checkOutput({tag, ".redir"},    32'(redirect_out),    32'h0);
      checkOutput({tag, ".redirpc"},  32'(redirect_pc_out), 32'h0);
   endtask

   lc3b_control_word addC, brC, trapC;

   initial begin
      addC  = mkCtrl(op_add,  alu_add, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
      brC   = mkCtrl(op_br,   alu_add, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
      trapC = mkCtrl(op_trap, alu_add, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);

      vecs[0]  = mkVec(addC, 16'h0005, 16'h0003, 16'h0002, 16'hBEEF, 4'd0, 2'b00, 2'b00,
                       16'h0000, 16'h0000, 16'h0008, 16'h0007, 16'hBEEF);
      vecs[1]  = mkVec(mkCtrl(op_shf, alu_sra, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0),
                       16'h8004, 16'h0000, 16'h0000, 16'h0000, 4'd2, 2'b00, 2'b00,
                       16'h0000, 16'h0000, 16'hE001, 16'h8004, 16'h0000);
      vecs[2]  = mkVec(mkCtrl(op_shf, alu_srl, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0),
                       16'h8004, 16'h0000, 16'h0000, 16'h0000, 4'd2, 2'b00, 2'b00,
                       16'h0000, 16'h0000, 16'h2001, 16'h8004, 16'h0000);
      vecs[3]  = mkVec(mkCtrl(op_add, alu_add, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0),
                       16'h1111, 16'h0000, 16'h0001, 16'h2222, 4'd0, 2'b01, 2'b00,
                       16'h00F0, 16'h0000, 16'h00F1, 16'h00F1, 16'h2222);
      vecs[4]  = mkVec(mkCtrl(op_and, alu_and, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0),
                       16'h33CC, 16'hAAAA, 16'h0000, 16'h5555, 4'd0, 2'b00, 2'b10,
                       16'h0000, 16'h0F0F, 16'h030C, 16'h33CC, 16'h0F0F);
      vecs[5]  = mkVec(mkCtrl(op_not, alu_not, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0),
                       16'h00FF, 16'h0000, 16'h0000, 16'h0000, 4'd0, 2'b00, 2'b00,
                       16'h0000, 16'h0000, 16'hFF00, 16'h00FF, 16'h0000);
      vecs[6]  = mkVec(mkCtrl(op_ldr, alu_pass, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0),
                       16'h0020, 16'h0000, 16'hFFF0, 16'h1357, 4'd0, 2'b00, 2'b01,
                       16'h0246, 16'h0000, 16'hFFF0, 16'h0010, 16'h0246);
      vecs[7]  = mkVec(mkCtrl(op_shf, alu_sll, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0),
                       16'h0001, 16'h0000, 16'h0000, 16'h0000, 4'd15, 2'b00, 2'b00,
                       16'h0000, 16'h0000, 16'h8000, 16'h0001, 16'h0000);
      vecs[8]  = mkVec(addC, 16'h7FFF, 16'h0001, 16'h0000, 16'h9ABC, 4'd0, 2'b11, 2'b11,
                       16'h1234, 16'h5678, 16'h8000, 16'h7FFF, 16'h9ABC);
      vecs[9]  = mkVec(addC, 16'hFFFF, 16'h0002, 16'h0003, 16'h0000, 4'd0, 2'b00, 2'b00,
                       16'h0000, 16'h0000, 16'h0001, 16'h0002, 16'h0000);
      vecs[10] = mkVec(mkCtrl(op_shf, alu_sra, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0),
                       16'h7000, 16'h0000, 16'h0000, 16'h0000, 4'd4, 2'b00, 2'b00,
                       16'h0000, 16'h0000, 16'h0700, 16'h7000, 16'h0000);
      vecs[11] = mkVec(mkCtrl(op_str, alu_add, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0),
                       16'h4000, 16'h0000, 16'h0006, 16'hCAFE, 4'd0, 2'b00, 2'b10,
                       16'h0000, 16'hD00D, 16'h4006, 16'h4006, 16'hD00D);

      // Idle inputs, then a genuine falling edge on reset_n.
      reset_n = 1'b1;
      stall_pipeline = 1'b0;
      applyStimulus('0, '0, '0, '0, '0, '0, '0, '0, '0, '0, '0, '0);
      valid_in = 1'b0;
      setXfer(16'h0000, 3'b000, 3'b000, 16'h0000);
      #1 reset_n = 1'b0;
      #1 checkAllZero("reset");
      tick();
      tick();
      reset_n = 1'b1;

      // Table-driven ALU / forwarding / address vectors.
      for (int i = 0; i < NVEC; i++) begin
         applyStimulus(vecs[i].ctrl, vecs[i].sr1, vecs[i].sr2, vecs[i].off6, vecs[i].destData,
                       vecs[i].shf, vecs[i].fa, vecs[i].fb, vecs[i].memD, vecs[i].wbD,
                       16'h1000 + 16'(i), 3'(i));
         tick();
         checkOutput($sformatf("v%0d.result", i), 32'(result_out),     32'(vecs[i].expResult));
         checkOutput($sformatf("v%0d.addr", i),   32'(addr_out),       32'(vecs[i].expAddr));
         checkOutput($sformatf("v%0d.store", i),  32'(store_data_out), 32'(vecs[i].expStore));
         checkOutput($sformatf("v%0d.valid", i),  32'(valid_out),      32'h1);
         checkOutput($sformatf("v%0d.redir", i),  32'(redirect_out),   32'h0);
         checkOutput($sformatf("v%0d.ctrl", i),   32'(ctrl_out),       32'(vecs[i].ctrl));
         checkOutput($sformatf("v%0d.dest", i),   32'(dest_out),       32'(i % 8));
         checkOutput($sformatf("v%0d.pc", i),     32'(pc_out),         32'(16'h1000 + 16'(i)));
      end

      // Taken BRz: one redirect pulse, two valid ops dropped, third accepted.
      applyStimulus(brC, '0, '0, '0, '0, '0, '0, '0, '0, '0, 16'h3002, 3'd0);
      setXfer(16'h0010, 3'b010, 3'b010, 16'h0000);
      tick();
      checkOutput("br.redir",   32'(redirect_out),    32'h1);
      checkOutput("br.redirpc", 32'(redirect_pc_out), 32'h3012);
      checkOutput("br.valid",   32'(valid_out),       32'h1);
      checkOutput("br.ctrl",    32'(ctrl_out),        32'(brC));
      setXfer(16'h0000, 3'b000, 3'b000, 16'h0000);
      for (int k = 0; k < 3; k++) begin
         applyStimulus(addC, 16'h0005, 16'h0003, '0, '0, '0, '0, '0, '0, '0, 16'h3004, 3'd1);
         tick();
         checkOutput($sformatf("brsq%0d.valid", k), 32'(valid_out),    (k == 2) ? 32'h1 : 32'h0);
         checkOutput($sformatf("brsq%0d.ctrl", k),  32'(ctrl_out),     (k == 2) ? 32'(addC) : 32'h0);
         checkOutput($sformatf("brsq%0d.redir", k), 32'(redirect_out), 32'h0);
      end
      checkOutput("brsq2.result", 32'(result_out), 32'h0008);

      // Not-taken BR (cc=100 vs nzp=010): no redirect and no squash.
      applyStimulus(brC, '0, '0, '0, '0, '0, '0, '0, '0, '0, 16'h3100, 3'd0);
      setXfer(16'h0010, 3'b010, 3'b100, 16'h0000);
      tick();
      checkOutput("brnt.redir", 32'(redirect_out), 32'h0);
      checkOutput("brnt.valid", 32'(valid_out),    32'h1);
      setXfer(16'h0000, 3'b000, 3'b000, 16'h0000);
      applyStimulus(addC, 16'h0005, 16'h0003, '0, '0, '0, '0, '0, '0, '0, 16'h3102, 3'd2);
      tick();
      checkOutput("brnt.next.valid",  32'(valid_out),  32'h1);
      checkOutput("brnt.next.result", 32'(result_out), 32'h0008);

      // Taken transfer during a squash cannot redirect; an empty slot still counts.
      applyStimulus(brC, '0, '0, '0, '0, '0, '0, '0, '0, '0, 16'h3002, 3'd0);
      setXfer(16'h0010, 3'b001, 3'b001, 16'h0000);
      tick();
      checkOutput("sq.br.redir", 32'(redirect_out), 32'h1);
      applyStimulus(trapC, '0, '0, '0, '0, '0, '0, '0, '0, '0, 16'h5000, 3'd7);
      setXfer(16'h0000, 3'b000, 3'b000, 16'h0080);
      tick();
      checkOutput("sq.trap.redir",   32'(redirect_out),    32'h0);
      checkOutput("sq.trap.valid",   32'(valid_out),       32'h0);
      checkOutput("sq.trap.redirpc", 32'(redirect_pc_out), 32'h3012);
      valid_in = 1'b0;
      tick();
      checkOutput("sq.empty.valid", 32'(valid_out), 32'h0);
      applyStimulus(addC, 16'h0005, 16'h0003, '0, '0, '0, '0, '0, '0, '0, 16'h3006, 3'd3);
      tick();
      checkOutput("sq.after.valid",  32'(valid_out),  32'h1);
      checkOutput("sq.after.result", 32'(result_out), 32'h0008);

      // TRAP x25 held by a 3-cycle stall: outputs keep the previous ADD.
      applyStimulus(trapC, '0, '0, '0, '0, '0, '0, '0, '0, '0, 16'h4002, 3'd7);
      setXfer(16'h0000, 3'b000, 3'b000, 16'h004A);
      stall_pipeline = 1'b1;
      for (int k = 0; k < 3; k++) begin
         tick();
         checkOutput($sformatf("stall%0d.result", k), 32'(result_out),   32'h0008);
         checkOutput($sformatf("stall%0d.redir", k),  32'(redirect_out), 32'h0);
         checkOutput($sformatf("stall%0d.ctrl", k),   32'(ctrl_out),     32'(addC));
      end
      stall_pipeline = 1'b0;
      tick();
      checkOutput("trap.redir",   32'(redirect_out),    32'h1);
      checkOutput("trap.redirpc", 32'(redirect_pc_out), 32'h004A);
      checkOutput("trap.result",  32'(result_out),      32'h4002);
      checkOutput("trap.valid",   32'(valid_out),       32'h1);
      // A stall right after the redirect holds the pulse and the squash count.
      applyStimulus(addC, 16'h0005, 16'h0003, '0, '0, '0, '0, '0, '0, '0, 16'h4004, 3'd1);
      setXfer(16'h0000, 3'b000, 3'b000, 16'h0000);
      stall_pipeline = 1'b1;
      tick();
      checkOutput("trapst.redir",  32'(redirect_out), 32'h1);
      checkOutput("trapst.result", 32'(result_out),   32'h4002);
      stall_pipeline = 1'b0;
      for (int k = 0; k < 3; k++) begin
         tick();
         checkOutput($sformatf("trapsq%0d.valid", k), 32'(valid_out),    (k == 2) ? 32'h1 : 32'h0);
         checkOutput($sformatf("trapsq%0d.redir", k), 32'(redirect_out), 32'h0);
      end

      // Reset asserted between edges in the middle of a squash.
      applyStimulus(brC, '0, '0, '0, '0, '0, '0, '0, '0, '0, 16'h3002, 3'd0);
      setXfer(16'h0010, 3'b100, 3'b100, 16'h0000);
      tick();
      checkOutput("rst.br.redir", 32'(redirect_out), 32'h1);
      setXfer(16'h0000, 3'b000, 3'b000, 16'h0000);
      applyStimulus(addC, 16'h0005, 16'h0003, '0, '0, '0, '0, '0, '0, '0, 16'h3004, 3'd1);
      tick();
      checkOutput("rst.sq.valid", 32'(valid_out), 32'h0);
      #2 reset_n = 1'b0;
      #1 checkAllZero("midrst");
      tick();
      reset_n = 1'b1;
      applyStimulus(addC, 16'h0005, 16'h0003, '0, '0, '0, '0, '0, '0, '0, 16'h3008, 3'd5);
      tick();
      checkOutput("postrst.valid",  32'(valid_out),  32'h1);
      checkOutput("postrst.result", 32'(result_out), 32'h0008);
      checkOutput("postrst.pc",     32'(pc_out),     32'h3008);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end

endmodule
